// File: rtl/tdm_mux8_tx.sv
// tdm_mux8_tx: 8-to-1 time-division transmitter. A parallel byte is accepted
// through a load/ready handshake and sent one channel at a time on Y. The
// channel index goes out on S2..S0, and each channel is held for DWELL cycles.
module tdm_mux8_tx #(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] d,
  input  logic       load,
  output logic       ready,
  input  logic       abort,
  output logic       Y,
  output logic       S2,
  output logic       S1,
  output logic       S0,
  output logic       frame_start,
  output logic       busy,
  output logic       done
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state, state_nxt;
  logic [7:0]      word, word_nxt;
  logic [2:0]      chan, chan_nxt;
  logic [DW_W-1:0] dwell, dwell_nxt;
  logic            done_nxt;
  logic            last_beat;

  assign last_beat = (state == SEND) && (chan == 3'd7) && (dwell == DW_LAST);
  assign ready     = (state == IDLE) || last_beat;

  // Next-state logic: word capture, dwell/channel stepping, abort and frame end.
  always_comb begin
    state_nxt = state;
    word_nxt  = word;
    chan_nxt  = chan;
    dwell_nxt = dwell;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          state_nxt = SEND;
          word_nxt  = d;
          chan_nxt  = 3'd0;
          dwell_nxt = '0;
        end
      end
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
          chan_nxt  = 3'd0;
          dwell_nxt = '0;
        end else if (dwell == DW_LAST) begin
          dwell_nxt = '0;
          if (chan == 3'd7) begin
            done_nxt = 1'b1;
            chan_nxt = 3'd0;
            if (load) begin
              word_nxt = d;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            chan_nxt = chan + 3'd1;
          end
        end else begin
          dwell_nxt = dwell + DW_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        chan_nxt  = 3'd0;
        dwell_nxt = '0;
      end
    endcase
  end

  // State, captured word and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      word  <= 8'h00;
      chan  <= 3'd0;
      dwell <= '0;
    end else begin
      state <= state_nxt;
      word  <= word_nxt;
      chan  <= chan_nxt;
      dwell <= dwell_nxt;
    end
  end

  // Output registers, loaded from the upcoming state so each beat appears
  // in the same cycle as the counters that describe it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Y           <= 1'b0;
      {S2, S1, S0} <= 3'b000;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      Y           <= (state_nxt == SEND) ? word_nxt[chan_nxt] : 1'b0;
      {S2, S1, S0} <= (state_nxt == SEND) ? chan_nxt : 3'b000;
      frame_start <= (state_nxt == SEND) && (chan_nxt == 3'd0) && (dwell_nxt == '0);
      busy        <= (state_nxt == SEND);
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_tdm_mux8_tx.sv
// Testbench for tdm_mux8_tx: two instances (DWELL=1 and DWELL=3) get the same
// stimulus. A beat-index reference model checks every output each cycle, and
// the scenario tasks add their own explicit expectations.
module tb_tdm_mux8_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] d = 8'h00;
  logic       load = 1'b0;
  logic       abort = 1'b0;

  logic [1:0] rdy, y, s2, s1, s0, fs, busy, done;

  int vectors = 0;
  int miscompares = 0;
  bit sb_on = 1'b0;

  int   dwell_of [2] = '{1, 3};
  bit   m_act  [2];
  bit   m_done [2];
  int   m_i    [2];
  logic [7:0] m_word [2];

  always #5 clk = ~clk;

  tdm_mux8_tx #(.DWELL(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .d(d), .load(load), .ready(rdy[0]), .abort(abort),
    .Y(y[0]), .S2(s2[0]), .S1(s1[0]), .S0(s0[0]),
    .frame_start(fs[0]), .busy(busy[0]), .done(done[0])
  );

  tdm_mux8_tx #(.DWELL(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .d(d), .load(load), .ready(rdy[1]), .abort(abort),
    .Y(y[1]), .S2(s2[1]), .S1(s1[1]), .S0(s0[1]),
    .frame_start(fs[1]), .busy(busy[1]), .done(done[1])
  );

  // Reference model: a frame is a run of 8*DWELL beats numbered 0..8*DWELL-1.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      int last;
      last = 8 * dwell_of[k] - 1;
      if (!rst_n) begin
        m_act[k] = 0; m_done[k] = 0; m_i[k] = 0; m_word[k] = 8'h00;
      end else if (m_act[k] && abort) begin
        m_act[k] = 0; m_done[k] = 0;
      end else if (m_act[k]) begin
        if (m_i[k] == last) begin
          m_done[k] = 1;
          if (load) begin m_word[k] = d; m_i[k] = 0; end
          else m_act[k] = 0;
        end else begin
          m_i[k] = m_i[k] + 1; m_done[k] = 0;
        end
      end else begin
        m_done[k] = 0;
        if (load) begin m_act[k] = 1; m_word[k] = d; m_i[k] = 0; end
      end
    end
  end

  // Per-cycle scoreboard against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb_on && rst_n) begin
      for (int k = 0; k < 2; k++) begin
        logic [7:0] got, exp;
        int ch;
        ch  = m_act[k] ? m_i[k] / dwell_of[k] : 0;
        exp = {(m_act[k] ? m_word[k][ch] : 1'b0), 3'(ch),
               (m_act[k] && m_i[k] == 0), m_act[k], m_done[k],
               (!m_act[k] || m_i[k] == 8 * dwell_of[k] - 1)};
        got = {y[k], s2[k], s1[k], s0[k], fs[k], busy[k], done[k], rdy[k]};
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("[TB] FAIL model_cycle inst%0d t=%0t: {Y,S,fs,busy,done,ready} got %b expected %b",
                   k, $time, got, exp);
        end
      end
    end
  end

  task automatic idle(input int n);
    load = 0; abort = 0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0; load = 0; abort = 0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({y[k], s2[k], s1[k], s0[k], fs[k], busy[k], done[k], rdy[k]} !== 8'b0000_0001) begin
        miscompares++;
        $display("[TB] FAIL reset_values inst%0d: got %b expected 00000001",
                 k, {y[k], s2[k], s1[k], s0[k], fs[k], busy[k], done[k], rdy[k]});
      end
    end
    rst_n = 1;
    sb_on = 1;
    @(negedge clk);
  endtask

  task automatic test_dwell1_frame();
    logic [7:0] w;
    w = 8'hA5;
    d = w; load = 1;
    @(negedge clk);
    load = 0;
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if ({y[0], s2[0], s1[0], s0[0], fs[0]} !== {w[i], 3'(i), (i == 0)}) begin
        miscompares++;
        $display("[TB] FAIL a5_beat%0d: {Y,S,fs} got %b expected %b",
                 i, {y[0], s2[0], s1[0], s0[0], fs[0]}, {w[i], 3'(i), (i == 0)});
      end
      @(negedge clk);
    end
    vectors++;
    if ({done[0], rdy[0], y[0], s2[0], s1[0], s0[0]} !== 6'b110000) begin
      miscompares++;
      $display("[TB] FAIL a5_end: {done,ready,Y,S} got %b expected 110000",
               {done[0], rdy[0], y[0], s2[0], s1[0], s0[0]});
    end
    idle(20);
  endtask

  task automatic test_dwell3_frame();
    int nbusy, ny, ndone;
    nbusy = 0; ny = 0; ndone = 0;
    d = 8'h01; load = 1;
    @(negedge clk);
    load = 0;
    repeat (28) begin
      nbusy += busy[1]; ny += y[1]; ndone += done[1];
      @(negedge clk);
    end
    vectors++;
    if (nbusy != 24 || ny != 3 || ndone != 1) begin
      miscompares++;
      $display("[TB] FAIL dwell3_frame: busy/y/done cycles got %0d/%0d/%0d expected 24/3/1",
               nbusy, ny, ndone);
    end
    idle(2);
  endtask

  task automatic test_back_to_back();
    d = 8'hFF; load = 1;
    @(negedge clk);
    d = 8'h00;
    repeat (8) @(negedge clk);
    vectors++;
    if ({s2[0], s1[0], s0[0], y[0], fs[0], done[0], busy[0]} !== 7'b0000111) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: {S,Y,fs,done,busy} got %b expected 0000111",
               {s2[0], s1[0], s0[0], y[0], fs[0], done[0], busy[0]});
    end
    idle(60);
  endtask

  task automatic test_abort();
    logic [7:0] cap;
    int ndone;
    d = 8'hF0; load = 1;
    @(negedge clk);
    load = 0;
    repeat (4) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    vectors++;
    if ({busy[0], y[0], s2[0], s1[0], s0[0], done[0]} !== 6'b000000) begin
      miscompares++;
      $display("[TB] FAIL abort_idle: {busy,Y,S,done} got %b expected 000000",
               {busy[0], y[0], s2[0], s1[0], s0[0], done[0]});
    end
    d = 8'h0F; load = 1;
    @(negedge clk);
    load = 0;
    cap = 8'h00; ndone = 0;
    repeat (8) begin
      cap = {y[0], cap[7:1]};
      @(negedge clk);
    end
    ndone = done[0];
    vectors++;
    if (cap !== 8'h0F || ndone != 1) begin
      miscompares++;
      $display("[TB] FAIL after_abort: bits got %h done %0d expected 0f done 1", cap, ndone);
    end
    idle(30);
  endtask

  task automatic test_async_reset();
    d = 8'h5A; load = 1;
    @(negedge clk);
    load = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({y[k], s2[k], s1[k], s0[k], fs[k], busy[k], done[k], rdy[k]} !== 8'b0000_0001) begin
        miscompares++;
        $display("[TB] FAIL async_reset inst%0d: got %b expected 00000001",
                 k, {y[k], s2[k], s1[k], s0[k], fs[k], busy[k], done[k], rdy[k]});
      end
    end
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    vectors++;
    if (rdy !== 2'b11 || done !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL after_reset: ready got %b done %b expected 11 / 00", rdy, done);
    end
  endtask

  task automatic test_data_toggle();
    logic [7:0] cap;
    d = 8'h3C; load = 1;
    @(negedge clk);
    load = 0;
    cap = 8'h00;
    repeat (8) begin
      cap = {y[0], cap[7:1]};
      d = 8'($urandom);
      @(negedge clk);
    end
    vectors++;
    if (cap !== 8'h3C) begin
      miscompares++;
      $display("[TB] FAIL data_toggle: bits got %h expected 3c", cap);
    end
    idle(30);
  endtask

  task automatic test_random();
    repeat (400) begin
      d     = 8'($urandom);
      load  = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      @(negedge clk);
    end
    idle(30);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_dwell1_frame();
    test_dwell3_frame();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_data_toggle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
